spi_flash_responder: RTL and testbench

Synthesizable SPI-flash responder: the slave end of the serial link driven by `spi_flash`. It oversamples `spi_clk`/`spi_cs`/`MOSI` on the system clock, decodes the flash command subset issued by the master, and drives `MISO` from a byte-wide memory read port. It acts as an FPGA-resident flash stand-in for system benches and loopback boards.

---
 rtl/spi_flash_responder_pkg.sv | 33 +++
 rtl/spi_flash_responder_if.sv | 23 ++
 rtl/spi_flash_responder_pin_sync.sv | 37 +++
 rtl/spi_flash_responder.sv | 178 +++++++++++++++++
 tb/tb_spi_flash_responder.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/spi_flash_responder_pkg.sv
// Shared constants, state encoding and command decode for the SPI flash responder.
package spi_flash_pkg;

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_RDID = 8'h9F;
    localparam logic [7:0] CMD_RDSR = 8'h05;

    localparam int unsigned SPI_SYNC_STAGES = 2;
    localparam int unsigned BIT_CNT_W       = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_ID,
        ST_STAT,
        ST_IGNORE
    } state_t;

    // Map a received command byte to the state that services it.
    function automatic state_t decode_cmd(input logic [7:0] cmd);
        state_t st;
        case (cmd)
            CMD_READ: st = ST_ADDR;
            CMD_RDID: st = ST_ID;
            CMD_RDSR: st = ST_STAT;
            default:  st = ST_IGNORE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/spi_flash_responder_if.sv
// SPI pins plus byte-wide memory read port seen by the flash responder.
interface spi_flash_responder_if #(
    parameter int unsigned ADDR_W = 24
);
    logic              spi_clk;
    logic              spi_cs;
    logic              MOSI;
    logic              MISO;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              busy;

    modport master (
        output spi_clk, spi_cs, MOSI, mem_data,
        input  MISO, mem_rd, mem_addr, busy
    );

    modport slave (
        input  spi_clk, spi_cs, MOSI, mem_data,
        output MISO, mem_rd, mem_addr, busy
    );
endinterface

// File: rtl/spi_flash_responder_pin_sync.sv
// Synchronizer plus history flop for one asynchronous pin, with registered
// one-cycle rise/fall strobes (pin-to-strobe latency of 3 sys_clk cycles).
module spi_pin_sync
    import spi_flash_pkg::*;
(
    input  logic sys_clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    localparam int unsigned LAST = SPI_SYNC_STAGES - 1;

    logic [SPI_SYNC_STAGES-1:0] r_sync;
    logic                       r_hist;
    logic                       r_rise;
    logic                       r_fall;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_sync <= '0;
            r_hist <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[LAST-1:0], i_pin};
            r_hist <= r_sync[LAST];
            r_rise <= r_sync[LAST] & ~r_hist;
            r_fall <= ~r_sync[LAST] & r_hist;
        end
    end

    assign o_level = r_sync[LAST];
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash stand-in: decodes READ/RDID/RDSR, streams memory bytes on MISO.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter logic [23:0] JEDEC_ID = 24'hEF4017,
    parameter logic [7:0]  STATUS   = 8'h00,
    parameter int unsigned ADDR_W   = 24
) (
    input  logic           sys_clk,
    input  logic           rst,
    spi_flash_responder_if.slave bus
);
    logic w_sclk_rise, w_sclk_fall, w_sclk_level_unused;
    logic w_cs_rise, w_cs_fall, w_cs_level;
    logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

    spi_pin_sync u_sync_clk (.sys_clk(sys_clk), .rst(rst), .i_pin(bus.spi_clk),
        .o_level(w_sclk_level_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));
    spi_pin_sync u_sync_cs (.sys_clk(sys_clk), .rst(rst), .i_pin(bus.spi_cs),
        .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall));
    spi_pin_sync u_sync_mosi (.sys_clk(sys_clk), .rst(rst), .i_pin(bus.MOSI),
        .o_level(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused));

    state_t                 r_state, w_state_nxt;
    logic [BIT_CNT_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
    logic [1:0]             r_byte_cnt, w_byte_cnt_nxt;
    logic [7:0]             r_rx_sh, w_rx_sh_nxt;
    logic [7:0]             r_tx_sh, w_tx_sh_nxt;
    logic [7:0]             r_pref, w_pref_nxt;
    logic [ADDR_W-1:0]      r_addr, w_addr_nxt;
    logic [ADDR_W-1:0]      r_mem_addr, w_mem_addr_nxt;
    logic                   r_mem_rd, w_mem_rd_nxt;
    logic                   r_rd_pend, w_rd_pend_nxt;
    logic                   r_miso, w_miso_nxt;
    logic                   r_busy;

    logic [7:0]             w_cmd;
    logic [7:0]             w_tx_byte;
    logic [ADDR_W-1:0]      w_addr_shift;
    logic [ADDR_W-1:0]      w_addr_inc;

    assign w_cmd        = {r_rx_sh[6:0], w_mosi};
    assign w_addr_shift = {r_addr[ADDR_W-2:0], w_mosi};
    assign w_addr_inc   = r_addr + ADDR_W'(1);

    // Byte loaded into the tx shifter at the first fall of each response byte.
    always_comb begin
        w_tx_byte = r_pref;
        case (r_state)
            ST_ID: begin
                case (r_byte_cnt)
                    2'd0:    w_tx_byte = JEDEC_ID[23:16];
                    2'd1:    w_tx_byte = JEDEC_ID[15:8];
                    2'd2:    w_tx_byte = JEDEC_ID[7:0];
                    default: w_tx_byte = 8'hFF;
                endcase
            end
            ST_STAT: w_tx_byte = STATUS;
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_byte_cnt_nxt = r_byte_cnt;
        w_rx_sh_nxt    = r_rx_sh;
        w_tx_sh_nxt    = r_tx_sh;
        w_addr_nxt     = r_addr;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_rd_nxt   = 1'b0;
        w_rd_pend_nxt  = r_mem_rd;
        w_pref_nxt     = r_rd_pend ? bus.mem_data : r_pref;
        w_miso_nxt     = r_miso;

        // CS edges override everything, including a coincident SPI clock rise.
        if (w_cs_rise || w_cs_fall) begin
            w_state_nxt    = w_cs_fall ? ST_CMD : ST_IDLE;
            w_bit_cnt_nxt  = '0;
            w_byte_cnt_nxt = '0;
            w_rx_sh_nxt    = '0;
            w_tx_sh_nxt    = '0;
            w_rd_pend_nxt  = 1'b0;
            w_pref_nxt     = r_pref;
        end else begin
            case (r_state)
                ST_CMD: begin
                    if (w_sclk_rise) begin
                        w_rx_sh_nxt = w_cmd;
                        if (r_bit_cnt == BIT_CNT_W'(7)) begin
                            w_state_nxt   = decode_cmd(w_cmd);
                            w_bit_cnt_nxt = '0;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                end
                ST_ADDR: begin
                    if (w_sclk_rise) begin
                        w_addr_nxt = w_addr_shift;
                        if (r_bit_cnt == BIT_CNT_W'(23)) begin
                            w_state_nxt    = ST_DATA;
                            w_bit_cnt_nxt  = '0;
                            w_mem_rd_nxt   = 1'b1;
                            w_mem_addr_nxt = w_addr_shift;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                end
                ST_DATA, ST_ID, ST_STAT: begin
                    if (w_sclk_rise) begin
                        if (r_bit_cnt == BIT_CNT_W'(7)) begin
                            w_bit_cnt_nxt = '0;
                            if (r_state == ST_DATA) begin
                                w_addr_nxt     = w_addr_inc;
                                w_mem_addr_nxt = w_addr_inc;
                                w_mem_rd_nxt   = 1'b1;
                            end
                            if (r_state == ST_ID && r_byte_cnt != 2'd3)
                                w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                    if (w_sclk_fall) begin
                        if (r_bit_cnt == '0) begin
                            w_miso_nxt  = w_tx_byte[7];
                            w_tx_sh_nxt = {w_tx_byte[6:0], 1'b0};
                        end else begin
                            w_miso_nxt  = r_tx_sh[7];
                            w_tx_sh_nxt = {r_tx_sh[6:0], 1'b0};
                        end
                    end
                end
                default: ;
            endcase
        end

        if (w_state_nxt inside {ST_IDLE, ST_CMD, ST_ADDR, ST_IGNORE} || w_cs_level)
            w_miso_nxt = 1'b1;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_rx_sh    <= '0;
            r_tx_sh    <= '0;
            r_pref     <= '0;
            r_addr     <= '0;
            r_mem_addr <= '0;
            r_mem_rd   <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_miso     <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_rx_sh    <= w_rx_sh_nxt;
            r_tx_sh    <= w_tx_sh_nxt;
            r_pref     <= w_pref_nxt;
            r_addr     <= w_addr_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_mem_rd   <= w_mem_rd_nxt;
            r_rd_pend  <= w_rd_pend_nxt;
            r_miso     <= w_miso_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    assign bus.MISO     = r_miso;
    assign bus.mem_rd   = r_mem_rd;
    assign bus.mem_addr = r_mem_addr;
    assign bus.busy     = r_busy;
endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: vector table of whole transactions
// plus hand sequences for abort, edge timing and reset mid-transaction.
module tb_spi_flash_responder;
    localparam int H = 8;   // sys_clk cycles per spi_clk half-period

    logic sys_clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [23:0] rd_q[$];

    always #5 sys_clk = ~sys_clk;

    spi_flash_responder_if #(.ADDR_W(24)) bus ();

    spi_flash_responder #(
        .JEDEC_ID(24'hEF4017),
        .STATUS  (8'h02),
        .ADDR_W  (24)
    ) dut (
        .sys_clk(sys_clk),
        .rst    (rst),
        .bus    (bus)
    );

    // Memory model: data = addr[7:0] ^ 0x5A, valid the cycle after mem_rd.
    always @(posedge sys_clk) begin
        if (bus.mem_rd === 1'b1) begin
            rd_q.push_back(bus.mem_addr);
            bus.mem_data <= bus.mem_addr[7:0] ^ 8'h5A;
        end
    end

    typedef struct {
        string       name;
        logic [7:0]  cmd;
        bit          has_addr;
        logic [23:0] addr;
        int          nbytes;
        logic [31:0] exp_data;
        int          exp_nrd;
        logic [23:0] exp_rd0;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            bus.MOSI = tx[7-i];
            repeat (H) @(negedge sys_clk);
            bus.spi_clk = 1'b1;
            rx = {rx[6:0], bus.MISO};
            repeat (H) @(negedge sys_clk);
            bus.spi_clk = 1'b0;
        end
    endtask

    task automatic cs_low(input string name);
        @(negedge sys_clk);
        bus.spi_cs = 1'b0;
        repeat (3) @(negedge sys_clk);
        check({name, "_busy_pre"}, 32'(bus.busy), 32'd0);
        @(negedge sys_clk);
        check({name, "_busy_rise"}, 32'(bus.busy), 32'd1);
        repeat (H) @(negedge sys_clk);
    endtask

    task automatic cs_high(input string name, input bit chk);
        @(negedge sys_clk);
        bus.spi_cs = 1'b1;
        if (chk) begin
            repeat (3) @(negedge sys_clk);
            check({name, "_busy_hold"}, 32'(bus.busy), 32'd1);
            @(negedge sys_clk);
            check({name, "_busy_fall"}, 32'(bus.busy), 32'd0);
            check({name, "_miso_idle"}, 32'(bus.MISO), 32'd1);
        end
        repeat (2 * H) @(negedge sys_clk);
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] rx;
        logic [7:0] expb;
        rd_q.delete();
        cs_low(v.name);
        spi_bits(v.cmd, 8, rx);
        if (v.has_addr) begin
            spi_bits(v.addr[23:16], 8, rx);
            spi_bits(v.addr[15:8], 8, rx);
            spi_bits(v.addr[7:0], 8, rx);
        end
        for (int k = 0; k < v.nbytes; k++) begin
            spi_bits(8'h00, 8, rx);
            expb = v.exp_data[31-8*k -: 8];
            check($sformatf("%s_byte%0d", v.name, k), 32'(rx), 32'(expb));
        end
        cs_high(v.name, 1'b1);
        check({v.name, "_nrd"}, 32'(rd_q.size()), 32'(v.exp_nrd));
        for (int k = 0; k < rd_q.size() && k < v.exp_nrd; k++)
            check($sformatf("%s_rdaddr%0d", v.name, k), 32'(rd_q[k]), 32'(24'(v.exp_rd0 + 24'(k))));
    endtask

    initial begin
        logic [7:0] rx;

        vecs[0] = '{"rdid",   8'h9F, 1'b0, 24'h000000, 4, 32'hEF4017FF, 0, 24'h000000};
        vecs[1] = '{"read",   8'h03, 1'b1, 24'h000100, 3, 32'h5A5B5800, 4, 24'h000100};
        vecs[2] = '{"wrap",   8'h03, 1'b1, 24'hFFFFFF, 2, 32'hA55A0000, 3, 24'hFFFFFF};
        vecs[3] = '{"ignore", 8'hAB, 1'b0, 24'h000000, 2, 32'hFFFF0000, 0, 24'h000000};
        vecs[4] = '{"rdsr",   8'h05, 1'b0, 24'h000000, 2, 32'h02020000, 0, 24'h000000};

        rst          = 1'b1;
        bus.spi_clk  = 1'b0;
        bus.spi_cs   = 1'b1;
        bus.MOSI     = 1'b0;
        bus.mem_data = 8'h00;
        repeat (3) @(negedge sys_clk);
        check("rst_miso",     32'(bus.MISO),     32'd1);
        check("rst_mem_rd",   32'(bus.mem_rd),   32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_busy",     32'(bus.busy),     32'd0);
        rst = 1'b0;
        repeat (10) @(negedge sys_clk);

        for (int i = 0; i < 5; i++)
            run_vec(vecs[i]);

        // Abort mid-address, then RDSR must return clean status with exact MISO latency.
        rd_q.delete();
        cs_low("abort");
        spi_bits(8'h03, 8, rx);
        spi_bits(8'hF0, 4, rx);
        cs_high("abort", 1'b1);
        check("abort_nrd", 32'(rd_q.size()), 32'd0);
        cs_low("abrdsr");
        spi_bits(8'h05, 8, rx);
        repeat (3) @(negedge sys_clk);
        check("abrdsr_miso_lat3", 32'(bus.MISO), 32'd1);
        @(negedge sys_clk);
        check("abrdsr_miso_lat4", 32'(bus.MISO), 32'd0);
        spi_bits(8'h00, 8, rx);
        check("abrdsr_byte0", 32'(rx), 32'h02);
        spi_bits(8'h00, 8, rx);
        check("abrdsr_byte1", 32'(rx), 32'h02);
        cs_high("abrdsr", 1'b1);

        // Reset during a READ with CS still low: responder must stay idle.
        cs_low("rstmid");
        spi_bits(8'h03, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h01, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 8, rx);
        check("rstmid_byte0", 32'(rx), 32'h5A);
        repeat (5) @(negedge sys_clk);
        check("rstmid_miso_pre", 32'(bus.MISO), 32'd0);
        rst = 1'b1;
        @(negedge sys_clk);
        rst = 1'b0;
        check("rstmid_miso",   32'(bus.MISO),   32'd1);
        check("rstmid_busy",   32'(bus.busy),   32'd0);
        check("rstmid_mem_rd", 32'(bus.mem_rd), 32'd0);
        rd_q.delete();
        spi_bits(8'h00, 8, rx);
        check("rstmid_after_rx",   32'(rx),          32'hFF);
        check("rstmid_after_busy", 32'(bus.busy),    32'd0);
        check("rstmid_after_nrd",  32'(rd_q.size()), 32'd0);
        cs_high("rstmid", 1'b0);

        run_vec(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
